// File: rtl/cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// cfg_loader_pkg
// Shared types for the FPGA configuration loader: sequencer state encoding,
// error codes reported on err_code, and a small state classification helper.
// ---------------------------------------------------------------------------
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NCFG    = 3'd1,
        RELEASE = 3'd2,
        SHIFT   = 3'd3,
        TRAILER = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_NSTATUS_TO = 2'd1;
    localparam logic [1:0] ERR_CRC        = 2'd2;
    localparam logic [1:0] ERR_ABORT      = 2'd3;

    // States in which a configuration sequence is in progress (busy=1, abortable)
    function automatic logic is_busy_state(input state_t st);
        case (st)
            NCFG, RELEASE, SHIFT, TRAILER: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cfg_loader_sync2.sv
// ---------------------------------------------------------------------------
// cfg_loader_sync2
// Two-flop synchroniser for an asynchronous level input.
//   clock   in  system clock
//   reset_n in  async active-low reset (both flops load RST_VAL)
//   d       in  asynchronous input
//   q       out synchronised output, 2 cycles latency
// ---------------------------------------------------------------------------
module cfg_loader_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter chain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/cfg_loader.sv
// ---------------------------------------------------------------------------
// cfg_loader
// Configuration loader for an Intel/Altera-style slave in passive serial
// (BUS_W=1) or fast passive parallel (BUS_W=8/16/32) mode. Pulses nCONFIG,
// waits for the nSTATUS handshake, streams host words through a one-word skid
// buffer onto data/dclk and finishes with EXTRA_DCLK trailing clocks.
//   clock, reset_n        system clock, async active-low reset
//   n_config   out        target nCONFIG
//   n_status   in         target nSTATUS (async)
//   conf_done  in         target CONF_DONE (async)
//   dclk, data out        configuration clock and data (LSB beat first)
//   msel       out        mode select constant
//   word, word_valid, word_ready   host word stream (valid/ready)
//   start, abort in       begin / cancel a sequence
//   busy, done, error, err_code out status (done/error/err_code sticky)
// ---------------------------------------------------------------------------
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int         DW         = 64,
    parameter int         BUS_W      = 1,
    parameter int         CLK_DIV    = 5,
    parameter int         NCFG_LOW   = 50,
    parameter int         TIMEOUT    = 100000,
    parameter int         EXTRA_DCLK = 2,
    parameter logic [3:0] MSEL       = 4'b0000
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic             n_config,
    input  logic             n_status,
    input  logic             conf_done,
    output logic             dclk,
    output logic [BUS_W-1:0] data,
    output logic [3:0]       msel,
    input  logic [DW-1:0]    word,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);

    localparam int BEATS   = DW / BUS_W;
    localparam int BEAT_W  = $clog2(BEATS + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int CNT_MAX = (TIMEOUT > NCFG_LOW) ? TIMEOUT : NCFG_LOW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TRL_W   = $clog2(EXTRA_DCLK + 2);

    localparam logic [BEAT_W-1:0] BEATS_V   = BEAT_W'(BEATS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  NCFG_LAST = CNT_W'((NCFG_LOW > 0) ? NCFG_LOW - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [TRL_W-1:0]  TRL_LAST  = TRL_W'((EXTRA_DCLK > 0) ? EXTRA_DCLK - 1 : 0);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DIV_W-1:0]   div_r;
    logic [BEAT_W-1:0]  beat_r;     // beats still to be clocked out of shreg_r
    logic [TRL_W-1:0]   trl_r;
    logic [DW-1:0]      shreg_r;
    logic [DW-1:0]      buf_r;
    logic               buf_full_r;
    logic               n_config_r;
    logic               dclk_r;
    logic [BUS_W-1:0]   data_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic [1:0]         err_code_r;

    logic               ns_sync_s;
    logic               cd_sync_s;
    logic               rise_s;
    logic               fall_s;
    logic               last_fall_s;
    logic               load_s;
    logic               ready_s;
    logic               xfer_s;
    logic               err_evt_s;
    logic [1:0]         err_sel_s;
    logic [DW-1:0]      shreg_shift_s;

    cfg_loader_sync2 #(.RST_VAL(1'b1)) u_sync_ns (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (n_status),
        .q       (ns_sync_s)
    );

    cfg_loader_sync2 #(.RST_VAL(1'b0)) u_sync_cd (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (conf_done),
        .q       (cd_sync_s)
    );

    // Decode DCLK edges, buffer hand-off and error events from registered state
    always_comb begin
        rise_s        = 1'b0;
        fall_s        = 1'b0;
        last_fall_s   = 1'b0;
        load_s        = 1'b0;
        ready_s       = 1'b0;
        err_evt_s     = 1'b0;
        err_sel_s     = ERR_NONE;
        shreg_shift_s = shreg_r >> BUS_W;
        if (state_r == SHIFT) begin
            // A low phase only runs while there is a beat to present; an empty
            // shreg parks dclk low (starvation) without advancing the divider.
            rise_s      = !dclk_r && (beat_r != BEAT_W'(0)) && (div_r == DIV_LAST);
            fall_s      = dclk_r && (div_r == DIV_LAST);
            last_fall_s = fall_s && (beat_r == BEAT_W'(1));
            // Reloading on the last falling edge keeps dclk gap-free across words.
            load_s      = buf_full_r && (((beat_r == BEAT_W'(0)) && !dclk_r) || last_fall_s);
            ready_s     = !buf_full_r || load_s;
        end else begin
            ready_s     = 1'b0;
        end
        if (is_busy_state(state_r) && abort) begin
            err_evt_s = 1'b1;
            err_sel_s = ERR_ABORT;
        end else if ((state_r == NCFG) && ns_sync_s && (cnt_r >= TO_LAST)) begin
            err_evt_s = 1'b1;
            err_sel_s = ERR_NSTATUS_TO;
        end else if ((state_r == RELEASE) && !ns_sync_s && (cnt_r >= TO_LAST)) begin
            err_evt_s = 1'b1;
            err_sel_s = ERR_NSTATUS_TO;
        end else if ((state_r == SHIFT) && !ns_sync_s) begin
            err_evt_s = 1'b1;
            err_sel_s = ERR_CRC;
        end else begin
            err_evt_s = 1'b0;
            err_sel_s = ERR_NONE;
        end
        xfer_s = word_valid && ready_s;
    end

    // Sequencer: state, target pin drivers, skid buffer, shifter and counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            div_r      <= '0;
            beat_r     <= '0;
            trl_r      <= '0;
            shreg_r    <= '0;
            buf_r      <= '0;
            buf_full_r <= 1'b0;
            n_config_r <= 1'b1;
            dclk_r     <= 1'b0;
            data_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            if (xfer_s) begin
                buf_r      <= word;
                buf_full_r <= 1'b1;
            end else if (load_s) begin
                buf_full_r <= 1'b0;
            end

            if (err_evt_s) begin
                state_r    <= ERROR;
                error_r    <= 1'b1;
                err_code_r <= err_sel_s;
                busy_r     <= 1'b0;
                n_config_r <= 1'b1;
                dclk_r     <= 1'b0;
                data_r     <= '0;
                beat_r     <= '0;
                buf_full_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE, DONE, ERROR: begin
                        if (start) begin
                            state_r    <= NCFG;
                            n_config_r <= 1'b0;
                            busy_r     <= 1'b1;
                            done_r     <= 1'b0;
                            error_r    <= 1'b0;
                            err_code_r <= ERR_NONE;
                            cnt_r      <= '0;
                            div_r      <= '0;
                            beat_r     <= '0;
                            dclk_r     <= 1'b0;
                            data_r     <= '0;
                            buf_full_r <= 1'b0;
                        end
                    end
                    NCFG: begin
                        if ((cnt_r >= NCFG_LAST) && !ns_sync_s) begin
                            state_r    <= RELEASE;
                            n_config_r <= 1'b1;
                            cnt_r      <= '0;
                        end else begin
                            cnt_r <= (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_W'(1);
                        end
                    end
                    RELEASE: begin
                        if (ns_sync_s) begin
                            state_r <= SHIFT;
                            div_r   <= '0;
                            beat_r  <= '0;
                        end else begin
                            cnt_r <= (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_W'(1);
                        end
                    end
                    SHIFT: begin
                        // CONF_DONE seen during a high phase lets that phase finish.
                        if (cd_sync_s && (!dclk_r || fall_s)) begin
                            state_r    <= (EXTRA_DCLK == 0) ? DONE : TRAILER;
                            done_r     <= (EXTRA_DCLK == 0);
                            busy_r     <= (EXTRA_DCLK != 0);
                            dclk_r     <= 1'b0;
                            div_r      <= '0;
                            trl_r      <= '0;
                            data_r     <= '0;
                            beat_r     <= '0;
                            buf_full_r <= 1'b0;
                        end else if (load_s) begin
                            shreg_r <= buf_r;
                            beat_r  <= BEATS_V;
                            data_r  <= buf_r[BUS_W-1:0];
                            dclk_r  <= 1'b0;
                            div_r   <= '0;
                        end else if (fall_s) begin
                            shreg_r <= shreg_shift_s;
                            beat_r  <= beat_r - BEAT_W'(1);
                            data_r  <= shreg_shift_s[BUS_W-1:0];
                            dclk_r  <= 1'b0;
                            div_r   <= '0;
                        end else if (rise_s) begin
                            dclk_r <= 1'b1;
                            div_r  <= '0;
                        end else if (dclk_r || (beat_r != BEAT_W'(0))) begin
                            div_r <= div_r + DIV_W'(1);
                        end else begin
                            div_r <= '0;
                        end
                    end
                    TRAILER: begin
                        if (div_r != DIV_LAST) begin
                            div_r <= div_r + DIV_W'(1);
                        end else if (!dclk_r) begin
                            dclk_r <= 1'b1;
                            div_r  <= '0;
                        end else begin
                            dclk_r <= 1'b0;
                            div_r  <= '0;
                            if (trl_r == TRL_LAST) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                            end else begin
                                trl_r <= trl_r + TRL_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        n_config_r <= 1'b1;
                        dclk_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign n_config   = n_config_r;
    assign dclk       = dclk_r;
    assign data       = data_r;
    assign msel       = MSEL;
    assign word_ready = ready_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign err_code   = err_code_r;

endmodule

// File: tb/tb_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_loader
// Self-checking bench for cfg_loader in FPP x8 mode with a small target model
// (nSTATUS follows nCONFIG and releases 10 cycles after nCONFIG rises).
// ---------------------------------------------------------------------------
module tb_cfg_loader;

    localparam int         DW         = 32;
    localparam int         BUS_W      = 8;
    localparam int         CLK_DIV    = 2;
    localparam int         NCFG_LOW   = 8;
    localparam int         TIMEOUT    = 100;
    localparam int         EXTRA_DCLK = 2;
    localparam logic [3:0] MSEL       = 4'b1010;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             n_config;
    logic             n_status;
    logic             conf_done = 1'b0;
    logic             dclk;
    logic [BUS_W-1:0] data;
    logic [3:0]       msel;
    logic [DW-1:0]    word = '0;
    logic             word_valid = 1'b0;
    logic             word_ready;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;

    // target model
    logic ns_model = 1'b1;
    int   rel_cnt = 10;
    logic ns_force_en = 1'b0;
    logic ns_pull = 1'b0;
    assign n_status = ns_force_en ? 1'b1 : (ns_model & ~ns_pull);

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;
    vec_t vecs[4];

    logic [7:0] cap_q[$];
    time        rise_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         widx = 0;
    int         nwords = 0;
    logic       feed_en = 1'b0;
    logic       xfer_pend = 1'b0;

    cfg_loader #(
        .DW(DW), .BUS_W(BUS_W), .CLK_DIV(CLK_DIV), .NCFG_LOW(NCFG_LOW),
        .TIMEOUT(TIMEOUT), .EXTRA_DCLK(EXTRA_DCLK), .MSEL(MSEL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .n_config(n_config), .n_status(n_status),
        .conf_done(conf_done), .dclk(dclk), .data(data), .msel(msel), .word(word),
        .word_valid(word_valid), .word_ready(word_ready), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clock = ~clock;

    // nSTATUS follows nCONFIG low, releases 10 cycles after nCONFIG rises
    always @(posedge clock) begin
        if (!n_config) begin
            ns_model <= 1'b0;
            rel_cnt  <= 0;
        end else if (rel_cnt < 10) begin
            rel_cnt <= rel_cnt + 1;
        end else begin
            ns_model <= 1'b1;
        end
    end

    // capture the data value sampled on each DCLK rising edge
    always @(posedge dclk) begin
        cap_q.push_back(data);
        rise_q.push_back($time);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200us");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] vbeat(input vec_t v, input int j);
        case (j)
            0:       return v.b0;
            1:       return v.b1;
            2:       return v.b2;
            default: return v.b3;
        endcase
    endfunction

    // one clock cycle; advance the word source and present the next word
    task automatic step();
        @(negedge clock);
        if (xfer_pend) widx++;
        word_valid = feed_en && (widx < nwords);
        word       = word_valid ? vecs[widx].word : 32'h0;
        xfer_pend  = word_valid && word_ready;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_caps(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (cap_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(cap_q.size()), 32'(n));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic setup_feed(input int first, input int last_excl);
        widx      = first;
        nwords    = last_excl;
        xfer_pend = 1'b0;
        feed_en   = 1'b1;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[1] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        vecs[2] = '{32'h00FF807F, 8'h7F, 8'h80, 8'hFF, 8'h00};
        vecs[3] = '{32'hA5C30F96, 8'h96, 8'h0F, 8'hC3, 8'hA5};

        // ---------------- reset state ----------------
        steps(3);
        check("rst_n_config", 32'(n_config), 32'd1);
        check("rst_dclk", 32'(dclk), 32'd0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_msel", 32'(msel), 32'hA);
        check("rst_word_ready", 32'(word_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_error", {30'd0, done, error}, 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        reset_n = 1'b1;
        steps(2);

        // ---------------- happy path ----------------
        cap_q.delete();
        rise_q.delete();
        setup_feed(0, 4);
        pulse_start();
        check("start_n_config_low", 32'(n_config), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        wait_caps(12, 400, "pp_stream_beats");
        conf_done = 1'b1;
        cyc = 0;
        while (!done && cyc < 200) begin
            step();
            cyc++;
        end
        check("pp_done", 32'(done), 32'd1);
        check("pp_capture_count", 32'(cap_q.size()), 32'd14);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (cap_q.size() > 4 * i + j)
                    check($sformatf("pp_word%0d_beat%0d", i, j), 32'(cap_q[4 * i + j]), 32'(vbeat(vecs[i], j)));
            end
        end
        if (cap_q.size() >= 14) begin
            check("pp_trailer_data0", 32'(cap_q[12]), 32'h0);
            check("pp_trailer_data1", 32'(cap_q[13]), 32'h0);
        end
        for (int i = 1; i < 12; i++) begin
            if (rise_q.size() > i)
                check($sformatf("pp_dclk_period%0d", i), 32'(rise_q[i] - rise_q[i - 1]), 32'(2 * CLK_DIV * 10));
        end
        check("pp_error", 32'(error), 32'd0);
        check("pp_err_code", 32'(err_code), 32'd0);
        check("pp_busy", 32'(busy), 32'd0);
        check("pp_n_config", 32'(n_config), 32'd1);
        conf_done = 1'b0;
        feed_en   = 1'b0;
        steps(5);

        // ---------------- nSTATUS timeout ----------------
        ns_force_en = 1'b1;
        pulse_start();
        check("to_done_cleared", 32'(done), 32'd0);
        cyc = 0;
        while (!error && cyc < 300) begin
            step();
            cyc++;
        end
        check("to_cycles", 32'(cyc), 32'd100);
        check("to_err_code", 32'(err_code), 32'd1);
        check("to_n_config", 32'(n_config), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        ns_force_en = 1'b0;
        steps(20);

        // ---------------- nSTATUS low mid-word (CRC) ----------------
        cap_q.delete();
        setup_feed(0, 4);
        pulse_start();
        wait_caps(2, 200, "crc_prestream_beats");
        ns_pull = 1'b1;
        cyc = 0;
        while (!error && cyc < 10) begin
            step();
            cyc++;
        end
        check("crc_latency", 32'(cyc), 32'd3);
        check("crc_err_code", 32'(err_code), 32'd2);
        check("crc_dclk", 32'(dclk), 32'd0);
        check("crc_n_config", 32'(n_config), 32'd1);
        ns_pull = 1'b0;
        feed_en = 1'b0;
        steps(20);
        pulse_start();
        check("restart_error_cleared", 32'(error), 32'd0);
        check("restart_err_code", 32'(err_code), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        // ---------------- starvation then abort with conf_done ----------------
        cap_q.delete();
        steps(150);
        check("starve_no_dclk", 32'(cap_q.size()), 32'd0);
        check("starve_no_error", 32'(error), 32'd0);
        check("starve_busy", 32'(busy), 32'd1);
        setup_feed(3, 4);
        wait_caps(4, 100, "starve_resume_beats");
        for (int j = 0; j < 4; j++) begin
            if (cap_q.size() > j)
                check($sformatf("starve_beat%0d", j), 32'(cap_q[j]), 32'(vbeat(vecs[3], j)));
        end
        steps(12);
        check("starve_stop", 32'(cap_q.size()), 32'd4);
        check("starve_dclk_low", 32'(dclk), 32'd0);
        conf_done = 1'b1;
        steps(2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_error", 32'(error), 32'd1);
        check("abort_err_code", 32'(err_code), 32'd3);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dclk", 32'(dclk), 32'd0);
        check("abort_n_config", 32'(n_config), 32'd1);
        conf_done = 1'b0;
        feed_en   = 1'b0;
        steps(10);
        check("abort_done_stays_low", 32'(done), 32'd0);

        // ---------------- reset during SHIFT ----------------
        cap_q.delete();
        setup_feed(0, 3);
        pulse_start();
        wait_caps(2, 200, "rst_prestream_beats");
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_n_config", 32'(n_config), 32'd1);
        check("arst_dclk", 32'(dclk), 32'd0);
        check("arst_data", 32'(data), 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_word_ready", 32'(word_ready), 32'd0);
        check("arst_flags", {28'd0, done, error, err_code}, 32'd0);
        feed_en   = 1'b0;
        xfer_pend = 1'b0;
        steps(3);
        reset_n = 1'b1;
        steps(5);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_n_config", 32'(n_config), 32'd1);
        check("post_rst_word_ready", 32'(word_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
